// File: rtl/normalizer16_4.sv
// Multi-cycle 16-bit normalizer: finds shf (0..15) with B = A << shf normalized.
// Define NORM_NIBBLE_SKIP_EN to let SHIFT jump 4 bits when the top nibble is redundant.
module normalizer16_4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic        mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] B,
    output logic [3:0]  shf,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   mode_q;
    logic   accept;
    logic   stop;
    logic   skip;

    assign accept = in_valid && in_ready;

    // Logical mode stops on a leading one; arithmetic stops once sign and next bit differ.
    assign stop = (mode_q ? (B[15] ^ B[14]) : B[15]) || (shf == 4'd15);

`ifdef NORM_NIBBLE_SKIP_EN
    assign skip = (shf <= 4'd11) &&
                  (mode_q ? ((&B[15:11]) || (~|B[15:11])) : (B[15:12] == 4'h0));
`else
    assign skip = 1'b0;
`endif

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    // NOTE: state_next gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (A == 16'h0000) ? DONE : SHIFT;
            SHIFT:   if (stop) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: result registers hold their value everywhere except accept and SHIFT steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            B      <= 16'h0000;
            shf    <= 4'd0;
            zero   <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        B      <= A;
                        shf    <= 4'd0;
                        zero   <= (A == 16'h0000);
                        mode_q <= mode;
                    end
                end
                SHIFT: begin
                    if (!stop) begin
                        if (skip) begin
                            B   <= B << 4;
                            shf <= shf + 4'd4;
                        end else begin
                            B   <= B << 1;
                            shf <= shf + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_normalizer16_4.sv
// Self-checking bench for normalizer16_4: directed requests, scoreboard of expected results,
// latency, backpressure and asynchronous reset abort.
module tb_normalizer16_4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] B;
    logic [3:0]  shf;
    logic        zero;

    typedef struct {
        logic [15:0] b;
        logic [3:0]  shf;
        logic        zero;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fails;

    normalizer16_4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .B         (B),
        .shf       (shf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef NORM_NIBBLE_SKIP_EN
    localparam int LAT_0920 = 3;
    localparam int LAT_0001 = 8;
    localparam int LAT_FFFF = 8;
`else
    localparam int LAT_0920 = 6;
    localparam int LAT_0001 = 17;
    localparam int LAT_FFFF = 17;
`endif

    // Present a request, push its expectation, then wait for out_valid and compare.
    task automatic issue(input logic [15:0] a, input logic m, input logic [15:0] eb,
                         input logic [3:0] es, input logic ez, input int elat);
        exp_t e;
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1'b1);
        A        = a;
        mode     = m;
        in_valid = 1'b1;
        e.b = eb; e.shf = es; e.zero = ez; e.lat = elat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = 16'hDEAD;
        mode     = ~m;
    endtask

    task automatic wait_result(input string tag);
        int   lat;
        exp_t e;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_out_valid"}, out_valid, 1'b1);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, lat, e.lat);
            check({tag, "_B"}, B, e.b);
            check({tag, "_shf"}, shf, e.shf);
            check({tag, "_zero"}, zero, e.zero);
            check({tag, "_in_ready_busy"}, in_ready, 1'b0);
        end
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, out_valid, 1'b0);
        check({tag, "_in_ready_idle"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] hb;
        logic [3:0]  hs;
        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 16'h0000;
        mode      = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_B", B, 16'h0000);
        check("reset_shf", shf, 4'd0);
        check("reset_zero", zero, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_in_ready", in_ready, 1'b1);

        issue(16'h0920, 1'b0, 16'h9200, 4'd4, 1'b0, LAT_0920);
        wait_result("log_0920");
        consume("log_0920");
        check("hold_B_idle", B, 16'h9200);
        check("hold_shf_idle", shf, 4'd4);

        issue(16'h9201, 1'b0, 16'h9201, 4'd0, 1'b0, 2);
        wait_result("log_9201");
        consume("log_9201");

        issue(16'hF201, 1'b1, 16'h9008, 4'd3, 1'b0, 5);
        wait_result("ari_F201");
        consume("ari_F201");

        issue(16'hFFFF, 1'b1, 16'h8000, 4'd15, 1'b0, LAT_FFFF);
        wait_result("ari_FFFF");
        consume("ari_FFFF");

        issue(16'h0000, 1'b0, 16'h0000, 4'd0, 1'b1, 1);
        wait_result("log_zero");
        consume("log_zero");

        issue(16'h0000, 1'b1, 16'h0000, 4'd0, 1'b1, 1);
        wait_result("ari_zero");
        consume("ari_zero");

        issue(16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0, LAT_0001);
        wait_result("log_0001");
        consume("log_0001");

        issue(16'h2000, 1'b1, 16'h4000, 4'd1, 1'b0, 3);
        wait_result("ari_2000");
        consume("ari_2000");

        // Backpressure: result must stay put and new requests must be ignored.
        issue(16'h0920, 1'b0, 16'h9200, 4'd4, 1'b0, LAT_0920);
        wait_result("bp");
        hb = B;
        hs = shf;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            A        = 16'h0003;
            mode     = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_B", B, hb);
            check("bp_shf", shf, hs);
            check("bp_zero", zero, 1'b0);
            check("bp_in_ready", in_ready, 1'b0);
        end
        consume("bp");
        check("bp_B_after", B, 16'h9200);

        // Reset mid-operation aborts with no result and no clock edge needed.
        issue(16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0, LAT_0001);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_B", B, 16'h0000);
        check("abort_shf", shf, 4'd0);
        check("abort_zero", zero, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_result", out_valid, 1'b0);
        end

        issue(16'h4000, 1'b0, 16'h8000, 4'd1, 1'b0, 3);
        wait_result("post_reset_4000");
        consume("post_reset_4000");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
